// File: rtl/axi_lite_mem_bridge_if.sv
// AXI4-lite slave channels plus the single-port memory request/response
// signals of axi_lite_mem_bridge, bundled as one interface.
// slave  : bridge view.  master : interconnect + memory view.
interface axi_lite_mem_bridge_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
);
   localparam int SW = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [SW-1:0]         s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [DATA_WIDTH-1:0] s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;

   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [SW-1:0]         mem_wmask;
   logic                  mem_wen;
   logic                  mem_wvalid;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic                  mem_ren;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready, mem_wvalid, mem_rdata, mem_rvalid,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
             s_rresp, s_rvalid, mem_waddr, mem_wdata, mem_wmask, mem_wen,
             mem_raddr, mem_ren
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready, mem_wvalid, mem_rdata, mem_rvalid,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
             s_rresp, s_rvalid, mem_waddr, mem_wdata, mem_wmask, mem_wen,
             mem_raddr, mem_ren
   );
endinterface

// File: rtl/axi_lite_mem_bridge.sv
// AXI4-lite slave to single-port memory bridge.
// One-entry AW/W/AR buffers, fair write/read arbitration onto the memory
// port, address-window decode (out-of-window -> SLVERR, memory untouched).
// Optional watchdog: define MEM_TIMEOUT_EN to abort memory accesses that
// take TIMEOUT_CYCLES cycles without a done strobe.
module axi_lite_mem_bridge #(
   parameter int                    DATA_WIDTH     = 64,
   parameter int                    ADDR_WIDTH     = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter logic [ADDR_WIDTH-1:0] MEM_BYTES      = 'h10000,
   parameter int                    TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   rstn,
   axi_lite_mem_bridge_if.slave   bus,
   output logic [2:0]             debug_state,
   output logic                   debug_last_rd
);
   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WMEM  = 3'd1,
      RMEM  = 3'd2,
      WRESP = 3'd3,
      RRESP = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [SW-1:0]         w_strb_q, w_strb_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  arready_q, arready_d;
   logic                  last_rd_q, last_rd_d;
   logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]         mem_wmask_q, mem_wmask_d;
   logic                  mem_wen_q, mem_wen_d;
   logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
   logic                  mem_ren_q, mem_ren_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
   logic [31:0]           cnt_q, cnt_d;
   logic                  tmo;
   assign tmo = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   logic                  unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Window decode: offsets wrap, so addresses below BASE land out of window.
   logic [ADDR_WIDTH-1:0] wr_off, rd_off;
   logic                  wr_in_win, rd_in_win;
   logic                  wr_pend, rd_pend, grant_wr, grant_rd;

   assign wr_off    = aw_addr_q - BASE_ADDR;
   assign rd_off    = ar_addr_q - BASE_ADDR;
   assign wr_in_win = (wr_off < MEM_BYTES);
   assign rd_in_win = (rd_off < MEM_BYTES);
   assign wr_pend   = aw_full_q & w_full_q;
   assign rd_pend   = ar_full_q;
   // On a tie, the side that did not win last time goes first.
   assign grant_wr  = wr_pend & (~rd_pend | last_rd_q);
   assign grant_rd  = rd_pend & ~grant_wr;

   // Next-state: buffer capture, arbitration, memory and response phases.
   always_comb begin
      state_d     = state_q;
      aw_full_d   = aw_full_q;
      aw_addr_d   = aw_addr_q;
      w_full_d    = w_full_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      ar_full_d   = ar_full_q;
      ar_addr_d   = ar_addr_q;
      last_rd_d   = last_rd_q;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      mem_wen_d   = mem_wen_q;
      mem_raddr_d = mem_raddr_q;
      mem_ren_d   = mem_ren_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      rvalid_d    = rvalid_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      // ready is only high while the buffer is empty, so capture and the
      // grant-time clear below never hit the same buffer in one cycle
      if (bus.s_awvalid && awready_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = bus.s_awaddr;
      end
      if (bus.s_wvalid && wready_q) begin
         w_full_d = 1'b1;
         w_data_d = bus.s_wdata;
         w_strb_d = bus.s_wstrb;
      end
      if (bus.s_arvalid && arready_q) begin
         ar_full_d = 1'b1;
         ar_addr_d = bus.s_araddr;
      end

      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               last_rd_d = 1'b0;
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
               cnt_d     = '0;
`endif
               if (wr_in_win) begin
                  mem_waddr_d = wr_off;
                  mem_wdata_d = w_data_q;
                  mem_wmask_d = w_strb_q;
                  mem_wen_d   = 1'b1;
                  state_d     = WMEM;
               end else begin
                  bvalid_d = 1'b1;
                  bresp_d  = 2'b10;
                  state_d  = WRESP;
               end
            end else if (grant_rd) begin
               last_rd_d = 1'b1;
               ar_full_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
               cnt_d     = '0;
`endif
               if (rd_in_win) begin
                  mem_raddr_d = rd_off;
                  mem_ren_d   = 1'b1;
                  state_d     = RMEM;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = 2'b10;
                  rdata_d  = '0;
                  state_d  = RRESP;
               end
            end
         end
         WMEM: begin
`ifdef MEM_TIMEOUT_EN
            cnt_d = cnt_q + 32'd1;
`endif
            if (bus.mem_wvalid) begin
               mem_wen_d = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = 2'b00;
               state_d   = WRESP;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo) begin
               mem_wen_d = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = 2'b10;
               state_d   = WRESP;
            end
`endif
         end
         RMEM: begin
`ifdef MEM_TIMEOUT_EN
            cnt_d = cnt_q + 32'd1;
`endif
            if (bus.mem_rvalid) begin
               mem_ren_d = 1'b0;
               rvalid_d  = 1'b1;
               rresp_d   = 2'b00;
               rdata_d   = bus.mem_rdata;
               state_d   = RRESP;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo) begin
               mem_ren_d = 1'b0;
               rvalid_d  = 1'b1;
               rresp_d   = 2'b10;
               rdata_d   = '0;
               state_d   = RRESP;
            end
`endif
         end
         WRESP: begin
            if (bus.s_bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         RRESP: begin
            if (bus.s_rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      awready_d = ~aw_full_d;
      wready_d  = ~w_full_d;
      arready_d = ~ar_full_d;
   end

   // State register; reset clears every output and empties the buffers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         aw_full_q   <= 1'b0;
         aw_addr_q   <= '0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         ar_full_q   <= 1'b0;
         ar_addr_q   <= '0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         arready_q   <= 1'b0;
         last_rd_q   <= 1'b1;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         mem_wen_q   <= 1'b0;
         mem_raddr_q <= '0;
         mem_ren_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
         rvalid_q    <= 1'b0;
         rresp_q     <= 2'b00;
         rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         aw_full_q   <= aw_full_d;
         aw_addr_q   <= aw_addr_d;
         w_full_q    <= w_full_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         ar_full_q   <= ar_full_d;
         ar_addr_q   <= ar_addr_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         arready_q   <= arready_d;
         last_rd_q   <= last_rd_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         mem_wen_q   <= mem_wen_d;
         mem_raddr_q <= mem_raddr_d;
         mem_ren_q   <= mem_ren_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rvalid_q    <= rvalid_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.s_awready  = awready_q;
   assign bus.s_wready   = wready_q;
   assign bus.s_arready  = arready_q;
   assign bus.s_bvalid   = bvalid_q;
   assign bus.s_bresp    = bresp_q;
   assign bus.s_rvalid   = rvalid_q;
   assign bus.s_rresp    = rresp_q;
   assign bus.s_rdata    = rdata_q;
   assign bus.mem_waddr  = mem_waddr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.mem_wen    = mem_wen_q;
   assign bus.mem_raddr  = mem_raddr_q;
   assign bus.mem_ren    = mem_ren_q;
   assign debug_state    = state_q;
   assign debug_last_rd  = last_rd_q;
endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Scoreboard bench for axi_lite_mem_bridge: stimulus tasks push expected
// memory requests and B/R responses; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_axi_lite_mem_bridge;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam logic [63:0] BASE = 64'h1000;
   localparam logic [63:0] MB   = 64'h10000;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axi_lite_mem_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
   logic [2:0] dbg_state;
   logic       dbg_last_rd;

   axi_lite_mem_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MEM_BYTES(MB),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .debug_state(dbg_state), .debug_last_rd(dbg_last_rd)
   );

   typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] mask; } mw_t;
   typedef struct { logic [63:0] data; logic [1:0] resp; } r_t;
   mw_t         exp_mw[$];
   logic [63:0] exp_mr[$];
   logic [1:0]  exp_b[$];
   r_t          exp_r[$];

   int errors = 0, checks = 0;
   int cyc = 0;
   int aw_cap = 0, w_cap = 0, ar_cap = 0, b_rise = 0, r_rise = 0;
   int n_mw = 0, overlaps = 0;
   int wr_wait = 0, rd_wait = 0;
   bit hang = 1'b0;
   logic [63:0] rd_val = '0;
   string order = "";

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   // memory model: done after wr_wait/rd_wait wait cycles of an enable
   initial begin
      int wc = 0, rc = 0;
      bus.mem_wvalid = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_wvalid = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = rd_val;
         if (bus.mem_wen) begin
            if (!hang && wc == wr_wait) bus.mem_wvalid = 1'b1;
            wc++;
         end else wc = 0;
         if (bus.mem_ren) begin
            if (!hang && rc == rd_wait) bus.mem_rvalid = 1'b1;
            rc++;
         end else rc = 0;
      end
   end

   // memory-side monitor
   initial begin
      logic pw = 1'b0, pr = 1'b0;
      logic [63:0] hw = '0, hr = '0;
      mw_t e;
      forever begin
         @(negedge clk);
         if (bus.mem_wen && bus.mem_ren) overlaps++;
         if (bus.mem_wen && !pw) begin
            n_mw++;
            order = {order, "W"};
            hw = bus.mem_waddr;
            if (exp_mw.size() == 0) fail("mem_wen unexpected");
            else begin
               e = exp_mw.pop_front();
               chk("mem_waddr", bus.mem_waddr, e.addr);
               chk("mem_wdata", bus.mem_wdata, e.data);
               chk("mem_wmask", 64'(bus.mem_wmask), 64'(e.mask));
            end
         end else if (bus.mem_wen) chk("mem_waddr stable", bus.mem_waddr, hw);
         if (bus.mem_ren && !pr) begin
            order = {order, "R"};
            hr = bus.mem_raddr;
            if (exp_mr.size() == 0) fail("mem_ren unexpected");
            else chk("mem_raddr", bus.mem_raddr, exp_mr.pop_front());
         end else if (bus.mem_ren) chk("mem_raddr stable", bus.mem_raddr, hr);
         pw = bus.mem_wen;
         pr = bus.mem_ren;
      end
   end

   // response monitor
   initial begin
      logic pb = 1'b0, pr = 1'b0;
      r_t e;
      forever begin
         @(negedge clk);
         if (bus.s_bvalid && !pb) b_rise = cyc;
         if (bus.s_rvalid && !pr) r_rise = cyc;
         if (bus.s_bvalid && bus.s_bready) begin
            if (exp_b.size() == 0) fail("bvalid unexpected");
            else chk("bresp", 64'(bus.s_bresp), 64'(exp_b.pop_front()));
         end
         if (bus.s_rvalid && bus.s_rready) begin
            if (exp_r.size() == 0) fail("rvalid unexpected");
            else begin
               e = exp_r.pop_front();
               chk("rresp", 64'(bus.s_rresp), 64'(e.resp));
               chk("rdata", bus.s_rdata, e.data);
            end
         end
         pb = bus.s_bvalid;
         pr = bus.s_rvalid;
      end
   end

   task automatic send_aw(input logic [63:0] a);
      int n = 0;
      @(negedge clk);
      bus.s_awaddr = a; bus.s_awvalid = 1'b1;
      while (!bus.s_awready && n < 200) begin @(negedge clk); n++; end
      if (!bus.s_awready) fail("aw accept timeout"); else aw_cap = cyc + 1;
      @(negedge clk);
      bus.s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s);
      int n = 0;
      @(negedge clk);
      bus.s_wdata = d; bus.s_wstrb = s; bus.s_wvalid = 1'b1;
      while (!bus.s_wready && n < 200) begin @(negedge clk); n++; end
      if (!bus.s_wready) fail("w accept timeout"); else w_cap = cyc + 1;
      @(negedge clk);
      bus.s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [63:0] a);
      int n = 0;
      @(negedge clk);
      bus.s_araddr = a; bus.s_arvalid = 1'b1;
      while (!bus.s_arready && n < 200) begin @(negedge clk); n++; end
      if (!bus.s_arready) fail("ar accept timeout"); else ar_cap = cyc + 1;
      @(negedge clk);
      bus.s_arvalid = 1'b0;
   endtask

   task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                     input bit hit, input logic [63:0] off, input logic [1:0] resp);
      mw_t e;
      e.addr = off; e.data = d; e.mask = s;
      if (hit) exp_mw.push_back(e);
      exp_b.push_back(resp);
      fork
         send_aw(a);
         send_w(d, s);
      join
   endtask

   task automatic rd(input logic [63:0] a, input bit hit, input logic [63:0] off,
                     input logic [63:0] d, input logic [1:0] resp);
      r_t e;
      e.data = d; e.resp = resp;
      if (hit) exp_mr.push_back(off);
      exp_r.push_back(e);
      send_ar(a);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_mw.size() + exp_mr.size() + exp_b.size() + exp_r.size()) != 0 && n < 300) begin
         @(negedge clk); n++;
      end
      if ((exp_mw.size() + exp_mr.size() + exp_b.size() + exp_r.size()) != 0) fail(nm);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap, n;
      bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
      bus.s_wvalid = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
      bus.s_bready = 1'b1; bus.s_rready = 1'b1;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst awready", 64'(bus.s_awready), 0);
      chk("rst wready", 64'(bus.s_wready), 0);
      chk("rst arready", 64'(bus.s_arready), 0);
      chk("rst bvalid", 64'(bus.s_bvalid), 0);
      chk("rst rvalid", 64'(bus.s_rvalid), 0);
      chk("rst mem_wen", 64'(bus.mem_wen), 0);
      chk("rst mem_ren", 64'(bus.mem_ren), 0);
      chk("rst state", 64'(dbg_state), 0);
      chk("rst last_rd", 64'(dbg_last_rd), 1);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("awready after reset", 64'(bus.s_awready), 1);

      // 1: AW alone, W later; zero-wait write
      exp_mw.push_back('{addr: 64'h10, data: 64'hDEADBEEF, mask: 8'hFF});
      exp_b.push_back(2'b00);
      fork
         send_aw(64'h1010);
         begin repeat (3) @(negedge clk); send_w(64'hDEADBEEF, 8'hFF); end
      join
      drain("t1 drain");
      chk("t1 latency", 64'(b_rise - w_cap), 2);
      chk("t1 last_rd", 64'(dbg_last_rd), 0);

      // 2: read with 4 memory wait cycles
      rd_wait = 4; rd_val = 64'hDEADBEEF;
      rd(64'h1010, 1'b1, 64'h10, 64'hDEADBEEF, 2'b00);
      drain("t2 drain");
      chk("t2 latency", 64'(r_rise - ar_cap), 6);

      // 3: write and read pending together, four times
      order = ""; wr_wait = 1; rd_wait = 1; rd_val = 64'h5555AAAA5555AAAA;
      for (int i = 0; i < 4; i++) begin
         fork
            wr(64'h1100 + 64'(i * 8), 64'h100 + 64'(i), 8'hFF, 1'b1, 64'h100 + 64'(i * 8), 2'b00);
            rd(64'h1200 + 64'(i * 8), 1'b1, 64'h200 + 64'(i * 8), 64'h5555AAAA5555AAAA, 2'b00);
         join
         drain("t3 drain");
      end
      checks++;
      if (order != "WRWRWRWR") begin
         errors++;
         $display("FAIL t3 order: got %s, expected WRWRWRWR", order);
      end

      // top-of-window write, partial strobe, 2 wait cycles
      wr_wait = 2;
      wr(64'h10FF8, 64'h0123456789ABCDEF, 8'h0F, 1'b1, 64'hFFF8, 2'b00);
      drain("edge drain");
      chk("edge latency", 64'(b_rise - w_cap), 4);
      wr_wait = 0; rd_wait = 0;

      // 4: out-of-window accesses
      rd(64'h11000, 1'b0, 0, 64'h0, 2'b10);
      drain("t4a drain");
      chk("t4a latency", 64'(r_rise - ar_cap), 1);
      rd(64'h0FF8, 1'b0, 0, 64'h0, 2'b10);
      drain("t4b drain");
      chk("t4b latency", 64'(r_rise - ar_cap), 1);
      wr(64'h11000, 64'h77, 8'hFF, 1'b0, 0, 2'b10);
      drain("t4c drain");
      chk("t4c latency", 64'(b_rise - w_cap), 1);

      // 5: B back-pressure with a new write buffered meanwhile
      @(posedge clk); #1 bus.s_bready = 1'b0;
      wr(64'h20000, 64'h1, 8'hFF, 1'b0, 0, 2'b10);
      n = 0;
      while (!bus.s_bvalid && n < 50) begin @(negedge clk); n++; end
      if (!bus.s_bvalid) fail("t5 bvalid timeout");
      snap = n_mw;
      fork
         wr(64'h1028, 64'hCAFE, 8'h3C, 1'b1, 64'h28, 2'b00);
      join_none
      repeat (5) begin
         @(negedge clk);
         chk("t5 bvalid held", 64'(bus.s_bvalid), 1);
         chk("t5 bresp held", 64'(bus.s_bresp), 2'b10);
         chk("t5 state", 64'(dbg_state), 3);
      end
      chk("t5 aw buffered", 64'(bus.s_awready), 0);
      chk("t5 no grant", 64'(n_mw), 64'(snap));
      @(posedge clk); #1 bus.s_bready = 1'b1;
      drain("t5 drain");

      // 6: reset while in RMEM
      hang = 1'b1;
      rd(64'h1030, 1'b1, 64'h30, 64'h0, 2'b00);
      n = 0;
      while (!bus.mem_ren && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("t6 in RMEM", 64'(dbg_state), 2);
      rstn = 1'b0;
      @(negedge clk);
      chk("t6 mem_ren", 64'(bus.mem_ren), 0);
      chk("t6 rvalid", 64'(bus.s_rvalid), 0);
      chk("t6 state", 64'(dbg_state), 0);
      chk("t6 last_rd", 64'(dbg_last_rd), 1);
      exp_r.delete();
      hang = 1'b0;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6 arready", 64'(bus.s_arready), 1);

`ifdef MEM_TIMEOUT_EN
      // watchdog: no done -> SLVERR after 8 cycles in RMEM/WMEM
      hang = 1'b1; rd_val = 64'h1234;
      rd(64'h1040, 1'b1, 64'h40, 64'h0, 2'b10);
      drain("tmo rd drain");
      chk("tmo rd latency", 64'(r_rise - ar_cap), 9);
      wr(64'h1048, 64'h99, 8'hFF, 1'b1, 64'h48, 2'b10);
      drain("tmo wr drain");
      chk("tmo wr latency", 64'(b_rise - w_cap), 9);
      // done on the timeout edge wins
      hang = 1'b0; rd_wait = 7;
      rd(64'h1050, 1'b1, 64'h50, 64'h1234, 2'b00);
      drain("tmo tie drain");
      chk("tmo tie latency", 64'(r_rise - ar_cap), 9);
      rd_wait = 0;
`endif

      chk("mem_wen/mem_ren overlap", 64'(overlaps), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
